// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - UART receiver with start-glitch rejection, break handling and optional parity.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_framed #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 break_hold;
    logic                 par_bad;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx      <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic parity_bit;
    logic parity_err;

    assign par_bad      = ((^shift) ^ parity_bit) != ODD;
    assign o_Parity_Err = parity_err;
`else
    assign par_bad      = 1'b0;
    assign o_Parity_Err = 1'b0;
`endif

    assign o_Busy = (state != IDLE);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            break_hold  <= 1'b0;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= '0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit  <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx) state <= START;
                end
                // A low that has vanished by mid-bit is treated as noise.
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        state   <= rx ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt    <= '0;
                        parity_bit <= rx;
                        state      <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt    <= '0;
                        state      <= CLEANUP;
                        break_hold <= !rx;
                        if (!rx) begin
                            o_Frame_Err <= 1'b1;
                        end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                            parity_err <= 1'b1;
`endif
                        end else begin
                            o_RX_DV   <= 1'b1;
                            o_RX_Byte <= shift;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // After a bad stop bit, wait out a break so it is not read as a new start.
                CLEANUP: begin
                    if (!break_hold || rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - scoreboard bench for uart_rx_framed (8-bit and 7-bit builds).
module tb_uart_rx_framed;

    localparam int CPB  = 217;
    localparam int CPB7 = 16;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic       dv8, fe8, pe8, busy8;
    logic [7:0] byte8;
    logic       dv7, fe7, pe7, busy7;
    logic [6:0] byte7;

    typedef struct {
        bit         dv;
        bit         fe;
        bit         pe;
        logic [8:0] data;
    } exp_t;

    exp_t       q8[$];
    exp_t       q7[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last8    = 8'h00;

    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(PODD)) dut8 (
        .i_Clk(clk), .i_Rst(rst), .i_RX_Serial(rx8),
        .o_RX_DV(dv8), .o_RX_Byte(byte8), .o_Frame_Err(fe8),
        .o_Parity_Err(pe8), .o_Busy(busy8)
    );

    uart_rx_framed #(.CLKS_PER_BIT(CPB7), .DATA_BITS(7), .PARITY_ODD(PODD)) dut7 (
        .i_Clk(clk), .i_Rst(rst), .i_RX_Serial(rx7),
        .o_RX_DV(dv7), .o_RX_Byte(byte7), .o_Frame_Err(fe7),
        .o_Parity_Err(pe7), .o_Busy(busy7)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dv8 || fe8 || pe8) begin
                if (q8.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out8 actual dv=%0b fe=%0b pe=%0b required none", dv8, fe8, pe8);
                end else begin
                    e = q8.pop_front();
                    check("flags8", {29'd0, dv8, fe8, pe8}, {29'd0, e.dv, e.fe, e.pe});
                    if (e.dv) check("byte8", {24'd0, byte8}, {23'd0, e.data});
                end
            end
            if (dv7 || fe7 || pe7) begin
                if (q7.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out7 actual dv=%0b fe=%0b pe=%0b required none", dv7, fe7, pe7);
                end else begin
                    e = q7.pop_front();
                    check("flags7", {29'd0, dv7, fe7, pe7}, {29'd0, e.dv, e.fe, e.pe});
                    if (e.dv) check("byte7", {25'd0, byte7}, {23'd0, e.data});
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rx8 = v;
        else rx7 = v;
        repeat (n) @(negedge clk);
    endtask

    // Reference: a word is accepted iff the stop bit is high and (when enabled) parity holds.
    task automatic send_frame(input int sel, input logic [8:0] data, input bit bad_par, input int stop_low);
        int         nb;
        int         cpb;
        logic [8:0] m;
        logic [8:0] d;
        exp_t       e;
        nb  = (sel == 0) ? 8 : 7;
        cpb = (sel == 0) ? CPB : CPB7;
        m   = (sel == 0) ? 9'h0FF : 9'h07F;
        d   = data & m;
        e.fe   = (stop_low > 0);
        e.pe   = PAR_EN && bad_par && !e.fe;
        e.dv   = !e.fe && !e.pe;
        e.data = d;
        if (sel == 0) begin
            q8.push_back(e);
            if (e.dv) last8 = d[7:0];
        end else begin
            q7.push_back(e);
        end
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < nb; i++) drive(sel, d[i], cpb);
        if (PAR_EN) drive(sel, logic'(($countones(d) + PODD + int'(bad_par)) % 2), cpb);
        if (stop_low > 0) begin
            drive(sel, 1'b0, cpb * stop_low);
            if (sel == 0) check("busy_in_break", {31'd0, busy8}, 32'd1);
        end
        drive(sel, 1'b1, cpb);
    endtask

    initial begin
        logic [8:0] r;
        int         sl;
        bit         bp;

        repeat (3) @(negedge clk);
        check("rst_dv8", {31'd0, dv8}, 0);
        check("rst_fe8", {31'd0, fe8}, 0);
        check("rst_pe8", {31'd0, pe8}, 0);
        check("rst_busy8", {31'd0, busy8}, 0);
        check("rst_byte8", {24'd0, byte8}, 0);
        check("rst_busy7", {31'd0, busy7}, 0);
        rst = 1'b0;
        drive(0, 1'b1, 20);

        send_frame(0, 9'h0A5, 1'b0, 0);
        check("byte_a5", {24'd0, byte8}, 32'h0A5);
        check("idle_after_a5", {31'd0, busy8}, 0);

        drive(0, 1'b0, 50);
        drive(0, 1'b1, CPB * 2);
        check("glitch_idle", {31'd0, busy8}, 0);
        check("glitch_byte", {24'd0, byte8}, {24'd0, last8});

        send_frame(0, 9'h000, 1'b0, 3);
        repeat (5) @(negedge clk);
        check("break_idle", {31'd0, busy8}, 0);
        check("break_byte", {24'd0, byte8}, {24'd0, last8});

`ifdef UART_RX_PARITY_EN
        send_frame(0, 9'h037, 1'b1, 0);
        check("par_bad_byte", {24'd0, byte8}, {24'd0, last8});
        send_frame(0, 9'h037, 1'b0, 0);
        check("par_ok_byte", {24'd0, byte8}, 32'h037);
`endif

        drive(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, CPB);
        drive(0, 1'b0, CPB / 2);
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dv", {31'd0, dv8}, 0);
        check("mid_rst_busy", {31'd0, busy8}, 0);
        check("mid_rst_byte", {24'd0, byte8}, 0);
        check("mid_rst_fe_pe", {30'd0, fe8, pe8}, 0);
        last8 = 8'h00;
        rx8 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, CPB);
        check("post_rst_idle", {31'd0, busy8}, 0);
        send_frame(0, 9'h05A, 1'b0, 0);
        check("byte_5a", {24'd0, byte8}, 32'h05A);

        for (int k = 0; k < 10; k++) begin
            r  = 9'($urandom_range(0, 255));
            sl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            bp = PAR_EN && (sl == 0) && ($urandom_range(0, 3) == 0);
            send_frame(0, r, bp, sl);
            drive(0, 1'b1, int'($urandom_range(0, CPB)));
            check("rand_byte", {24'd0, byte8}, {24'd0, last8});
        end

        drive(1, 1'b1, CPB7 * 2);
        send_frame(1, 9'h001, 1'b0, 0);
        send_frame(1, 9'h0FF, 1'b0, 0);
        send_frame(1, 9'h080, 1'b0, 0);
        drive(1, 1'b1, CPB7 * 2);
        check("b2b_last7", {25'd0, byte7}, 32'h000);

        repeat (10) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q7_drained", q7.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
